// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - program ROM byte-read bus between the fetch unit and ROM.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [7:0]        rom_data;
  logic              rom_ack;

  modport master (
    output rom_addr,
    output rom_rd,
    input  rom_data,
    input  rom_ack
  );

  modport slave (
    input  rom_addr,
    input  rom_rd,
    output rom_data,
    output rom_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - 8051 opcode/operand fetch with PC ownership.
// Optional FETCH_TIMEOUT_EN aborts a fetch when rom_ack stalls for TIMEOUT_CYCLES.
module instr_fetch_unit #(
  parameter int              ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = 16'h0000,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Fetch,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  instr_fetch_unit_if.master rom,
  output logic [7:0]        Opcode,
  output logic [7:0]        Operand1,
  output logic [7:0]        Operand2,
  output logic [1:0]        instr_len,
  output logic              instr_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_error
);

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_OP1, S_OP2, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_opcode;
  logic [7:0]        r_op1;
  logic [7:0]        r_op2;
  logic [1:0]        r_len;
  logic              r_valid;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_val;

  logic              w_fetching;
  logic              w_ack;
  logic [1:0]        w_len;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_timeout;

  function automatic logic [1:0] len_of(input logic [7:0] op);
    len_of = 2'd1;
    if (op[3:0] == 4'h1) len_of = 2'd2;
    case (op) inside
      8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75, 8'h85,
      8'h90, [8'hB4:8'hBF], 8'hD5:
        len_of = 2'd3;
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45,
      8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72,
      8'h74, 8'h76, 8'h77, [8'h78:8'h7F], 8'h80, 8'h82, 8'h86, 8'h87,
      [8'h88:8'h8F], 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2, 8'hA6, 8'hA7,
      [8'hA8:8'hAF], 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
      [8'hD8:8'hDF], 8'hE5, 8'hF5:
        len_of = 2'd2;
      default: ;
    endcase
  endfunction

  assign w_fetching = (r_state == S_OPC) || (r_state == S_OP1) || (r_state == S_OP2);
  assign w_ack      = w_fetching && rom.rom_ack;
  assign w_len      = len_of(rom.rom_data);
  assign w_pc_inc   = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait;
  logic             r_ferr;

  // Counts consecutive un-acked read cycles; any ack or idle cycle restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (w_fetching && !rom.rom_ack && !w_timeout) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  assign w_timeout   = w_fetching && !rom.rom_ack && (r_wait == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_error = r_ferr;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign fetch_error      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_opcode   <= 8'h00;
      r_op1      <= 8'h00;
      r_op2      <= 8'h00;
      r_len      <= 2'd0;
      r_valid    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
`ifdef FETCH_TIMEOUT_EN
      r_ferr     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A same-cycle load wins: OPC then reads from the loaded address.
          if (pc_load) r_pc <= pc_load_value;
          if (Fetch) begin
            r_state <= S_OPC;
            r_op1   <= 8'h00;
            r_op2   <= 8'h00;
`ifdef FETCH_TIMEOUT_EN
            r_ferr  <= 1'b0;
`endif
          end
        end
        S_OPC, S_OP1, S_OP2: begin
          if (pc_load) begin
            r_pend     <= 1'b1;
            r_pend_val <= pc_load_value;
          end
          if (w_ack) begin
            r_pc <= w_pc_inc;
            if (r_state == S_OPC) begin
              r_opcode <= rom.rom_data;
              r_len    <= w_len;
              if (w_len == 2'd1) begin
                r_state <= S_DONE;
                r_valid <= 1'b1;
              end else begin
                r_state <= S_OP1;
              end
            end else if (r_state == S_OP1) begin
              r_op1 <= rom.rom_data;
              if (r_len == 2'd3) begin
                r_state <= S_OP2;
              end else begin
                r_state <= S_DONE;
                r_valid <= 1'b1;
              end
            end else begin
              r_op2   <= rom.rom_data;
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            // Abort keeps the PC at the missing byte but still honours any jump.
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            if (pc_load)     r_pc <= pc_load_value;
            else if (r_pend) r_pc <= r_pend_val;
`ifdef FETCH_TIMEOUT_EN
            r_ferr  <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          if (pc_load)     r_pc <= pc_load_value;
          else if (r_pend) r_pc <= r_pend_val;
          r_pend  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom.rom_addr = r_pc;
  assign rom.rom_rd   = w_fetching;
  assign Opcode       = r_opcode;
  assign Operand1     = r_op1;
  assign Operand2     = r_op2;
  assign instr_len    = r_len;
  assign instr_valid  = r_valid;
  assign busy         = (r_state != S_IDLE);
  assign pc           = r_pc;

endmodule
